// File: rtl/ysyx_25010008_isram.sv
// Instruction SRAM slave for the fetch unit: valid/ready request and response channels,
// backdoor preload port, and a fixed plus optional LFSR-driven access delay.
module ysyx_25010008_isram #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned FIXED_LAT = 0,
    parameter int unsigned RAND_EN   = 0,
    parameter int unsigned RAND_BITS = 2,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data
);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(15 + (1 << RAND_BITS));
    // 33-bit upper bound so a window ending at 4 GiB cannot wrap to zero
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH << 2);
    localparam logic [1:0]  RESP_OKAY   = 2'd0;
    localparam logic [1:0]  RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    logic [1:0]       rst_sync_r;
    logic             rst_s;
    logic [31:0]      mem_r [DEPTH];
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, delay_s;
    logic [31:0]      addr_r, addr_s;
    logic [31:0]      rdata_r, rdata_s;
    logic [1:0]       rresp_r, rresp_s;
    logic             rvalid_r, rvalid_s;
    logic             arready_r, arready_s;
    logic [7:0]       lfsr_r;

    // Reset synchronizer: asserts immediately, releases on the second clock edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_sync_r <= 2'b11;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b0};
        end
    end
    assign rst_s = rst_sync_r[1];

    // Backdoor preload; the array itself is never cleared
    always_ff @(posedge clock) begin
        if (init_we && addr_ok(init_addr)) begin
            mem_r[word_idx(init_addr)] <= init_data;
        end
    end

    // Free-running delay LFSR
    always_ff @(posedge clock or posedge rst_s) begin
        if (rst_s) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Access delay loaded at accept time
    always_comb begin
        delay_s = CNT_W'(FIXED_LAT);
        if (RAND_EN != 0) begin
            delay_s = CNT_W'(FIXED_LAT) + CNT_W'(lfsr_r[RAND_BITS-1:0]);
        end else begin
            delay_s = CNT_W'(FIXED_LAT);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        addr_s    = addr_r;
        rdata_s   = rdata_r;
        rresp_s   = rresp_r;
        rvalid_s  = rvalid_r;
        arready_s = arready_r;
        case (state_r)
            IDLE: begin
                arready_s = 1'b1;
                if (arvalid && arready_r) begin
                    addr_s    = araddr;
                    cnt_s     = delay_s;
                    arready_s = 1'b0;
                    state_s   = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    rvalid_s = 1'b1;
                    state_s  = RESP;
                    if (addr_ok(addr_r)) begin
                        rdata_s = mem_r[word_idx(addr_r)];
                        rresp_s = RESP_OKAY;
                    end else begin
                        rdata_s = 32'h0000_0000;
                        rresp_s = RESP_SLVERR;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            RESP: begin
                if (rready) begin
                    rvalid_s  = 1'b0;
                    arready_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s   = IDLE;
                cnt_s     = {CNT_W{1'b0}};
                rvalid_s  = 1'b0;
                arready_s = 1'b1;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge rst_s) begin
        if (rst_s) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            addr_r    <= 32'h0000_0000;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
            rvalid_r  <= 1'b0;
            arready_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            addr_r    <= addr_s;
            rdata_r   <= rdata_s;
            rresp_r   <= rresp_s;
            rvalid_r  <= rvalid_s;
            arready_r <= arready_s;
        end
    end

    assign arready = arready_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
    assign rvalid  = rvalid_r;

endmodule

// File: tb/tb_ysyx_25010008_isram.sv
// Self-checking bench for ysyx_25010008_isram: four instances with different delay settings.
module tb_ysyx_25010008_isram;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic [3:0]  arvalid_v;
    logic        rready;
    logic        init_we;
    logic [31:0] init_addr;
    logic [31:0] init_data;
    logic [3:0]  arready_v;
    logic [3:0]  rvalid_v;
    logic [31:0] rdata_v [4];
    logic [1:0]  rresp_v [4];

    always #5 clock = ~clock;

    // u0: no delay, u1: FIXED_LAT=3, u2: FIXED_LAT=2, u3: random delay 0..3
    for (genvar g = 0; g < 4; g++) begin : g_dut
        ysyx_25010008_isram #(
            .BASE_ADDR(BASE),
            .DEPTH(DEPTH),
            .FIXED_LAT((g == 1) ? 3 : (g == 2) ? 2 : 0),
            .RAND_EN((g == 3) ? 1 : 0),
            .RAND_BITS(2),
            .LFSR_SEED(8'hA5)
        ) u_dut (
            .clock(clock),
            .reset(reset),
            .araddr(araddr),
            .arvalid(arvalid_v[g]),
            .arready(arready_v[g]),
            .rdata(rdata_v[g]),
            .rresp(rresp_v[g]),
            .rvalid(rvalid_v[g]),
            .rready(rready),
            .init_we(init_we),
            .init_addr(init_addr),
            .init_data(init_data)
        );
    end

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] d;
        logic [1:0]  r;
    } vec_t;

    exp_t        sb_q [$];
    vec_t        tbl [9];
    logic [31:0] img [DEPTH];
    int          n_chk = 0;
    int          n_pass = 0;
    int          hist [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", nm, act, req);
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
        init_addr = a;
        init_data = d;
        init_we   = 1'b1;
        @(negedge clock);
        init_we   = 1'b0;
    endtask

    // One request on instance k; optional backdoor write of bd_d to the same address
    // at the bd_at-th falling edge after acceptance, optional rready hold-off.
    task automatic fetch(input int k, input logic [31:0] a, input logic [31:0] ed,
                         input logic [1:0] er, input int hold, input int bd_at,
                         input logic [31:0] bd_d, output int lat);
        exp_t e;
        e.d = ed;
        e.r = er;
        sb_q.push_back(e);
        araddr       = a;
        arvalid_v[k] = 1'b1;
        rready       = (hold == 0);
        chk("arready_idle", 32'(arready_v[k]), 32'd1);
        @(negedge clock);
        arvalid_v[k] = 1'b0;
        lat = 0;
        if (bd_at == 0) begin
            init_addr = a; init_data = bd_d; init_we = 1'b1;
        end
        while (rvalid_v[k] !== 1'b1 && lat < 40) begin
            @(negedge clock);
            lat++;
            init_we = 1'b0;
            if (lat == bd_at) begin
                init_addr = a; init_data = bd_d; init_we = 1'b1;
            end
        end
        init_we = 1'b0;
        if (rvalid_v[k] !== 1'b1) begin
            chk("rvalid_timeout", 32'(rvalid_v[k]), 32'd1);
            sb_q.delete();
            return;
        end
        chk("arready_busy", 32'(arready_v[k]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("hold_rvalid", 32'(rvalid_v[k]), 32'd1);
            chk("hold_rdata", rdata_v[k], sb_q[0].d);
            chk("hold_rresp", 32'(rresp_v[k]), 32'(sb_q[0].r));
            chk("hold_arready", 32'(arready_v[k]), 32'd0);
        end
        e = sb_q.pop_front();
        chk("rdata", rdata_v[k], e.d);
        chk("rresp", 32'(rresp_v[k]), 32'(e.r));
        rready = 1'b1;
        @(negedge clock);
        chk("rvalid_drop", 32'(rvalid_v[k]), 32'd0);
        chk("arready_back", 32'(arready_v[k]), 32'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int lat;
        reset     = 1'b0;
        araddr    = 32'h0000_0000;
        arvalid_v = 4'b0000;
        rready    = 1'b0;
        init_we   = 1'b0;
        init_addr = 32'h0000_0000;
        init_data = 32'h0000_0000;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            chk("rst_arready", 32'(arready_v[k]), 32'd1);
            chk("rst_rvalid", 32'(rvalid_v[k]), 32'd0);
            chk("rst_rdata", rdata_v[k], 32'h0000_0000);
            chk("rst_rresp", 32'(rresp_v[k]), 32'd0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clock);

        for (int i = 0; i < DEPTH; i++) begin
            img[i] = (i == 0) ? 32'h0000_0413 : (32'h0A00_0000 ^ (32'(i) * 32'h0001_0203));
            bd_write(BASE + 32'(4 * i), img[i]);
        end
        // Writes that must be dropped: misaligned, just past the end, just below base
        bd_write(BASE + 32'd2, 32'hBAD0_0002);
        bd_write(BASE + 32'(4 * DEPTH), 32'hBAD0_0001);
        bd_write(BASE - 32'd4, 32'hBAD0_0003);

        tbl[0] = '{BASE,                          img[0],        2'd0};
        tbl[1] = '{BASE + 32'd4,                  img[1],        2'd0};
        tbl[2] = '{BASE + 32'(4 * (DEPTH - 1)),   img[DEPTH-1],  2'd0};
        tbl[3] = '{BASE + 32'd2,                  32'h0,         2'd2};
        tbl[4] = '{32'h2FFF_FFFC,                 32'h0,         2'd2};
        tbl[5] = '{BASE + 32'(4 * DEPTH),         32'h0,         2'd2};
        tbl[6] = '{32'hFFFF_FFFC,                 32'h0,         2'd2};
        tbl[7] = '{BASE + 32'd28,                 img[7],        2'd0};
        tbl[8] = '{BASE + 32'd1,                  32'h0,         2'd2};
        for (int i = 0; i < 9; i++) begin
            fetch(0, tbl[i].addr, tbl[i].d, tbl[i].r, 0, -1, 32'h0, lat);
            chk("lat_u0", 32'(lat), 32'd1);
        end

        // arvalid held through the handshake: one idle cycle before the re-accept
        araddr = BASE + 32'd4; arvalid_v[0] = 1'b1; rready = 1'b1;
        @(negedge clock); chk("bub_accept", 32'(arready_v[0]), 32'd0);
        @(negedge clock); chk("bub_rvalid1", 32'(rvalid_v[0]), 32'd1);
        chk("bub_rdata1", rdata_v[0], img[1]);
        @(negedge clock); chk("bub_idle_rv", 32'(rvalid_v[0]), 32'd0);
        chk("bub_idle_ar", 32'(arready_v[0]), 32'd1);
        @(negedge clock); chk("bub_reaccept", 32'(arready_v[0]), 32'd0);
        arvalid_v[0] = 1'b0;
        @(negedge clock); chk("bub_rvalid2", 32'(rvalid_v[0]), 32'd1);
        chk("bub_rdata2", rdata_v[0], img[1]);
        @(negedge clock); chk("bub_done", 32'(rvalid_v[0]), 32'd0);

        fetch(1, BASE + 32'd4, img[1], 2'd0, 5, -1, 32'h0, lat);
        chk("lat_u1_hold", 32'(lat), 32'd4);
        fetch(1, BASE + 32'd3, 32'h0, 2'd2, 0, -1, 32'h0, lat);
        chk("lat_u1_err", 32'(lat), 32'd4);

        fetch(2, BASE + 32'd20, 32'hDEAD_BEEF, 2'd0, 0, 1, 32'hDEAD_BEEF, lat);
        chk("lat_u2_bd_early", 32'(lat), 32'd3);
        img[5] = 32'hDEAD_BEEF;
        fetch(2, BASE + 32'd24, img[6], 2'd0, 0, 2, 32'hDEAD_BEEF, lat);
        chk("lat_u2_bd_same", 32'(lat), 32'd3);
        img[6] = 32'hDEAD_BEEF;
        fetch(2, BASE + 32'd24, img[6], 2'd0, 0, -1, 32'h0, lat);
        fetch(0, BASE, 32'h0000_0413, 2'd0, 0, -1, 32'h0, lat);

        for (int v = 0; v < 6; v++) hist[v] = 0;
        for (int i = 0; i < 200; i++) begin
            fetch(3, BASE + 32'(4 * (i % DEPTH)), img[i % DEPTH], 2'd0, 0, -1, 32'h0, lat);
            chk("rand_lat_range", 32'((lat >= 1) && (lat <= 4)), 32'd1);
            if (lat >= 1 && lat <= 4) hist[lat]++;
        end
        for (int v = 1; v <= 4; v++) chk("rand_lat_seen", 32'(hist[v] > 0), 32'd1);

        // Asynchronous reset between edges while u1 is in WAIT
        araddr = BASE + 32'd8; arvalid_v[1] = 1'b1; rready = 1'b1;
        @(negedge clock); arvalid_v[1] = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_rvalid", 32'(rvalid_v[1]), 32'd0);
        chk("arst_arready", 32'(arready_v[1]), 32'd1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("arst_discard", 32'(rvalid_v[1]), 32'd0);
        end
        fetch(1, BASE + 32'd12, img[3], 2'd0, 0, -1, 32'h0, lat);
        chk("lat_u1_after_rst", 32'(lat), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ysyx_25010008_isram.md
Name: ysyx_25010008_isram

Overview:
- Instruction-side memory slave directly upstream of the fetch unit.
- Accepts a word address over a valid/ready request channel and returns instruction data over a valid/ready response channel with AXI-style resp codes.
- Holds a synthesizable word array with a backdoor preload port.
- Adds a fixed plus optional pseudo-random access delay so fetch-stall handling is exercised.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte address of word 0 (equals the reset PC).
- DEPTH, 1024, number of 32-bit words; power of two.
- FIXED_LAT, 0, extra wait cycles added to every access (0..15).
- RAND_EN, 0, 1 adds LFSR-derived random delay to each access.
- RAND_BITS, 2, width of the random delay field (delay 0..2^RAND_BITS-1).
- LFSR_SEED, 8'hA5, nonzero LFSR reset value.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- araddr  in  32  fetch byte address.
- arvalid  in  1  request valid.
- arready  out  1  slave can accept a request.
- rdata  out  32  instruction word.
- rresp  out  2  0 = OKAY, 2 = SLVERR.
- rvalid  out  1  response valid.
- rready  in  1  master accepts response.
- init_we  in  1  backdoor word write enable.
- init_addr  in  32  backdoor byte address (same map as araddr).
- init_data  in  32  backdoor write data.

Behaviour:
- Reset (async assert, released synchronously inside): state=IDLE, arready=1, rvalid=0, rdata=0, rresp=0, cnt=0, lfsr=LFSR_SEED. The memory array is not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - arready=1.
  - On arvalid&&arready at edge E0: latch araddr, load cnt = FIXED_LAT + (RAND_EN ? lfsr[RAND_BITS-1:0] : 0), arready<=0, go to WAIT.
- WAIT:
  - If cnt==0: sample memory, rvalid<=1, go to RESP.
  - Else cnt<=cnt-1.
  - Result: rvalid rises at edge E0+1+D, where D is the loaded count. Minimum latency is 1 cycle.
- RESP:
  - rdata/rresp/rvalid are held stable until rready.
  - On rvalid&&rready: rvalid<=0, arready<=1, go to IDLE.
  - A new request is not accepted in the same cycle (one-cycle bubble).
- Sampling / error checks at the WAIT->RESP edge:
  - addr[1:0]!=0 -> rresp=2, rdata=0.
  - addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH -> rresp=2, rdata=0.
  - Otherwise rresp=0, rdata=mem[(addr-BASE_ADDR)>>2].
  - Address arithmetic is 32-bit unsigned; no wrap, and overflow counts as out of range.
- arvalid while not in IDLE is ignored. The request is not queued and is taken only once IDLE is re-entered and arvalid is still high.
- rready while rvalid=0 has no effect.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Advances every cycle regardless of state.
  - Value used is the one present at the accept edge.
- Backdoor write:
  - init_we writes mem at the next edge in any state, only if init_addr is aligned and in range; otherwise ignored.
  - Write on the same edge as the WAIT->RESP sample: the response carries the old word.
  - A write during WAIT to the pending word, before the sample edge: the response carries the new word.
- Reset mid-operation (WAIT or RESP): immediate return to IDLE with rvalid=0, and the in-flight response is discarded.
- cnt width is ceil(log2(15 + 2^RAND_BITS)); the maximum sum must not overflow.

Test Plan:
- Preload mem[0]=32'h00000413 via backdoor, FIXED_LAT=0, RAND_EN=0; request 32'h3000_0000 at edge E0 with rready=1 -> rvalid=1 after E0+1, rdata=32'h00000413, rresp=0, arready back to 1 one cycle later.
- FIXED_LAT=3; request 32'h3000_0004 -> rvalid rises at E0+4; hold rready=0 for 5 cycles -> rdata/rresp/rvalid unchanged, arready=0 throughout.
- Error cases:
  - Request 32'h3000_0002 (misaligned) -> rresp=2, rdata=0.
  - Request 32'h2FFF_FFFC -> rresp=2.
  - Request BASE_ADDR+4*DEPTH -> rresp=2.
  - Each case returns to IDLE normally afterwards.
- RAND_EN=1, RAND_BITS=2, 200 back-to-back fetches -> every latency in 1..4 cycles, all four values occur, data always matches the preloaded image.
- Reset asserted asynchronously mid-WAIT (between edges) -> rvalid=0 and arready=1 immediately; next request after release completes with correct data.
- Backdoor write of 32'hDEADBEEF to the pending word during WAIT with FIXED_LAT=2 -> response is 32'hDEADBEEF. The same write on the sample edge -> response is the old word.
